// File: rtl/traffic_phase_ctrl.sv
// Traffic-light phase sequencer timed from a free-running 5-bit ripple counter.
// Define TLC_PED_EN to add the pedestrian request / walk-phase feature.
module traffic_phase_ctrl #(
   parameter int unsigned GRN_DUR = 20,
   parameter int unsigned YEL_DUR = 4,
   parameter int unsigned RED_DUR = 2
`ifdef TLC_PED_EN
   ,
   parameter int unsigned MIN_GRN = 5,
   parameter int unsigned PED_DUR = 8
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] cnt_q,
   output logic       cnt_en,
   output logic       ns_red,
   output logic       ns_yel,
   output logic       ns_grn,
   output logic       ew_red,
   output logic       ew_yel,
   output logic       ew_grn,
   output logic [2:0] phase
`ifdef TLC_PED_EN
   ,
   input  logic       ped_req,
   output logic       ped_walk
`endif
);

   localparam int unsigned CW = 5;
   localparam logic [CW-1:0] GRN_T = CW'(GRN_DUR);
   localparam logic [CW-1:0] YEL_T = CW'(YEL_DUR);
   localparam logic [CW-1:0] RED_T = CW'(RED_DUR);
`ifdef TLC_PED_EN
   localparam logic [CW-1:0] MIN_T  = CW'(MIN_GRN);
   localparam logic [CW-1:0] WALK_T = CW'((PED_DUR > RED_DUR) ? PED_DUR : RED_DUR);
`endif

   typedef enum logic [2:0] {
      INIT = 3'd0,
      NS_G = 3'd1,
      NS_Y = 3'd2,
      AR1  = 3'd3,
      EW_G = 3'd4,
      EW_Y = 3'd5,
      AR2  = 3'd6
   } state_t;

   state_t        state;
   state_t        succ;
   logic [CW-1:0] s1, s2, s3;
   logic [CW-1:0] cnt_stb;
   logic [CW-1:0] start_cnt;
   logic [CW-1:0] elapsed;
   logic [CW-1:0] dur;
   logic          cut;
   logic          go;
   logic          in_grn;
   logic          to_ar;
`ifdef TLC_PED_EN
   logic          p1, p2, p3;
   logic          ped_rise;
   logic          ped_pend;
   logic          walk_arm;
`endif

   // Lamp pattern {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn} for a state.
   function automatic logic [5:0] lamp_dec(input state_t s);
      case (s)
         NS_G:    lamp_dec = 6'b001_100;
         NS_Y:    lamp_dec = 6'b010_100;
         EW_G:    lamp_dec = 6'b100_001;
         EW_Y:    lamp_dec = 6'b100_010;
         default: lamp_dec = 6'b100_100;
      endcase
   endfunction

   assign phase   = state;
   assign elapsed = cnt_stb - start_cnt;
   assign in_grn  = (state == NS_G) || (state == EW_G);
   assign to_ar   = (succ == AR1) || (succ == AR2);
`ifdef TLC_PED_EN
   assign ped_rise = p2 & ~p3;
`endif

   // Successor state, phase duration and the advance condition.
   always_comb begin
      succ = AR2;
      dur  = RED_T;
      cut  = 1'b0;
      case (state)
         INIT: begin succ = AR2;  dur = '0;    end
         NS_G: begin succ = NS_Y; dur = GRN_T; end
         NS_Y: begin succ = AR1;  dur = YEL_T; end
         AR1:  begin succ = EW_G; dur = RED_T; end
         EW_G: begin succ = EW_Y; dur = GRN_T; end
         EW_Y: begin succ = AR2;  dur = YEL_T; end
         AR2:  begin succ = NS_G; dur = RED_T; end
         default: begin succ = AR2; dur = '0; end
      endcase
`ifdef TLC_PED_EN
      if (((state == AR1) || (state == AR2)) && ped_walk)
         dur = WALK_T;
      if (in_grn && ped_pend && (elapsed >= MIN_T))
         cut = 1'b1;
`endif
      go = (elapsed >= dur) || cut;
   end

   // Count capture, phase register and registered lamp outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         cnt_stb   <= '0;
         start_cnt <= '0;
         cnt_en    <= 1'b0;
         ns_red    <= 1'b1;
         ns_yel    <= 1'b0;
         ns_grn    <= 1'b0;
         ew_red    <= 1'b1;
         ew_yel    <= 1'b0;
         ew_grn    <= 1'b0;
`ifdef TLC_PED_EN
         p1        <= 1'b0;
         p2        <= 1'b0;
         p3        <= 1'b0;
         ped_pend  <= 1'b0;
         walk_arm  <= 1'b0;
         ped_walk  <= 1'b0;
`endif
      end else begin
         s1 <= cnt_q;
         s2 <= s1;
         s3 <= s2;
         // Only accept a count seen twice in a row, so ripple transients drop out.
         if (s2 == s3)
            cnt_stb <= s2;
         cnt_en <= 1'b1;
         if (go) begin
            state     <= succ;
            start_cnt <= cnt_stb;
            {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn} <= lamp_dec(succ);
         end
`ifdef TLC_PED_EN
         p1 <= ped_req;
         p2 <= p1;
         p3 <= p2;
         if (go && to_ar) begin
            ped_walk <= walk_arm;
            walk_arm <= 1'b0;
         end else if (go) begin
            ped_walk <= 1'b0;
         end
         // A request seen by the end of green buys a walk in the next all-red.
         if (go && in_grn && (ped_pend || ped_rise)) begin
            walk_arm <= 1'b1;
            ped_pend <= 1'b0;
         end else if (ped_rise) begin
            ped_pend <= 1'b1;
         end
`else
         if (to_ar && in_grn) begin
         end
`endif
      end
   end

endmodule
